// File: rtl/input_pkg.sv
// Shared constants and types for the input debounce / auto-repeat block.
package input_pkg;

    localparam int N_INPUTS_DEF     = 32;
    localparam int TICK_BITS_DEF    = 17;
    localparam int REPEAT_DELAY_DEF = 24;
    localparam int REPEAT_RATE_DEF  = 4;

    // Width of the per-channel auto-repeat counter.
    localparam int RPT_W = 8;

    typedef logic [RPT_W-1:0] rpt_cnt_t;

    // Narrow an integer constant to the repeat-counter width.
    function automatic rpt_cnt_t to_rpt(input int v);
        return rpt_cnt_t'(v);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: window check, debounced level, edge pulses and auto-repeat.
module debounce_channel
    import input_pkg::*;
#(
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_i,
    input  logic in_i,
    input  logic rpt_en_i,
    output logic held_o,
    output logic pressed_o,
    output logic released_o,
    output logic repeat_o
);

    // Counter value that fires a repeat, and the reload that spaces later repeats.
    localparam rpt_cnt_t RPT_LAST   = to_rpt(REPEAT_DELAY - 1);
    localparam rpt_cnt_t RPT_RELOAD = to_rpt(REPEAT_DELAY - REPEAT_RATE);

    logic     pend_q, pend_d;
    logic     held_q, held_d;
    rpt_cnt_t rpt_q, rpt_d;
    logic     pressed_q, pressed_d;
    logic     released_q, released_d;
    logic     repeat_q, repeat_d;
    logic     mismatch_s;
    logic     accept_s;

    // Next-state: pending survives only while the raw level disagrees with the
    // debounced level; a change is accepted at a sample point with pending still set.
    always_comb begin
        mismatch_s = (in_i != held_q);
        accept_s   = sample_i & pend_q & mismatch_s;
        pend_d     = (sample_i | pend_q) & mismatch_s;
        held_d     = held_q;
        rpt_d      = rpt_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        repeat_d   = 1'b0;
        if (accept_s) begin
            held_d = ~held_q;
            rpt_d  = to_rpt(0);
            if (held_q == 1'b0) begin
                pressed_d = 1'b1;
                repeat_d  = 1'b1;
            end else begin
                released_d = 1'b1;
            end
        end else if (sample_i && held_q && rpt_en_i) begin
            if (rpt_q == RPT_LAST) begin
                repeat_d = 1'b1;
                rpt_d    = RPT_RELOAD;
            end else begin
                rpt_d = rpt_q + to_rpt(1);
            end
        end else begin
            rpt_d = rpt_q;
        end
    end

    // State and pulse registers; reset adopts the current raw level with no events.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q     <= 1'b0;
            held_q     <= in_i;
            rpt_q      <= to_rpt(0);
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            held_q     <= held_d;
            rpt_q      <= rpt_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            repeat_q   <= repeat_d;
        end
    end

    assign held_o     = held_q;
    assign pressed_o  = pressed_q;
    assign released_o = released_q;
    assign repeat_o   = repeat_q;

endmodule

// File: rtl/input_debounce_repeat.sv
// Multi-channel debouncer with auto-repeat; owns the shared sample-tick counter.
module input_debounce_repeat
    import input_pkg::*;
#(
    parameter int N_INPUTS     = N_INPUTS_DEF,
    parameter int TICK_BITS    = TICK_BITS_DEF,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_INPUTS-1:0] inputs,
    input  logic [N_INPUTS-1:0] repeat_en,
    output logic [N_INPUTS-1:0] held_down,
    output logic [N_INPUTS-1:0] just_pressed,
    output logic [N_INPUTS-1:0] just_released,
    output logic [N_INPUTS-1:0] repeat_pulse,
    output logic                tick
);

    logic [TICK_BITS-1:0] cnt_q, cnt_d;
    logic                 tick_q;
    logic                 sample_s;

    // Sample point is the cycle in which the free-running counter reads zero.
    always_comb begin
        sample_s = (cnt_q == {TICK_BITS{1'b0}});
        cnt_d    = cnt_q + TICK_BITS'(1);
    end

    // Tick counter and the registered tick pulse that follows each sample point.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= {TICK_BITS{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= sample_s;
        end
    end

    assign tick = tick_q;

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_ch
        debounce_channel #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .sample_i   (sample_s),
            .in_i       (inputs[g]),
            .rpt_en_i   (repeat_en[g]),
            .held_o     (held_down[g]),
            .pressed_o  (just_pressed[g]),
            .released_o (just_released[g]),
            .repeat_o   (repeat_pulse[g])
        );
    end

endmodule

// File: tb/tb_input_debounce_repeat.sv
// Directed bench with a counting/arithmetic reference model checked every cycle.
module tb_input_debounce_repeat;

    localparam int NI     = 4;
    localparam int TB     = 3;
    localparam int DELAY  = 3;
    localparam int RATE   = 2;
    localparam int PERIOD = 1 << TB;

    logic          clk;
    logic          rst_n;
    logic [NI-1:0] inputs;
    logic [NI-1:0] repeat_en;
    logic [NI-1:0] held_down;
    logic [NI-1:0] just_pressed;
    logic [NI-1:0] just_released;
    logic [NI-1:0] repeat_pulse;
    logic          tick;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    input_debounce_repeat #(
        .N_INPUTS     (NI),
        .TICK_BITS    (TB),
        .REPEAT_DELAY (DELAY),
        .REPEAT_RATE  (RATE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inputs        (inputs),
        .repeat_en     (repeat_en),
        .held_down     (held_down),
        .just_pressed  (just_pressed),
        .just_released (just_released),
        .repeat_pulse  (repeat_pulse),
        .tick          (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: cycles counted since reset, per-window mismatch tallies,
    // and the number of enabled ticks since the last press.
    int            m_cyc;
    bit            have_prev;
    int            win_len  [NI];
    int            win_mm   [NI];
    int            en_ticks [NI];
    logic [NI-1:0] m_held;
    logic [NI-1:0] exp_jp, exp_jr, exp_rp;
    logic          exp_tick;
    logic [NI-1:0] jp_v, jr_v, rp_v, nh_v;
    bit            smp;
    int            mm;

    always begin
        @(posedge clk);
        if (!rst_n) begin
            m_cyc     = 0;
            have_prev = 1'b0;
            m_held    = inputs;
            exp_jp    = 4'b0000;
            exp_jr    = 4'b0000;
            exp_rp    = 4'b0000;
            exp_tick  = 1'b0;
            for (int i = 0; i < NI; i++) begin
                win_len[i]  = 0;
                win_mm[i]   = 0;
                en_ticks[i] = 0;
            end
        end else begin
            smp  = ((m_cyc % PERIOD) == 0);
            jp_v = 4'b0000;
            jr_v = 4'b0000;
            rp_v = 4'b0000;
            nh_v = m_held;
            for (int i = 0; i < NI; i++) begin
                mm = (inputs[i] != m_held[i]) ? 1 : 0;
                win_len[i] += 1;
                win_mm[i]  += mm;
                if (smp) begin
                    if (have_prev && (win_mm[i] == win_len[i])) begin
                        nh_v[i] = ~m_held[i];
                        if (nh_v[i]) begin
                            jp_v[i] = 1'b1;
                            rp_v[i] = 1'b1;
                        end else begin
                            jr_v[i] = 1'b1;
                        end
                        en_ticks[i] = 0;
                    end else if (m_held[i] && repeat_en[i]) begin
                        en_ticks[i] += 1;
                        if ((en_ticks[i] == DELAY) ||
                            ((en_ticks[i] > DELAY) && (((en_ticks[i] - DELAY) % RATE) == 0)))
                            rp_v[i] = 1'b1;
                    end
                    win_len[i] = 1;
                    win_mm[i]  = mm;
                end
            end
            if (smp) have_prev = 1'b1;
            m_held   = nh_v;
            exp_jp   = jp_v;
            exp_jr   = jr_v;
            exp_rp   = rp_v;
            exp_tick = smp;
            m_cyc++;
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always begin
        @(negedge clk);
        if (chk_on) begin
            checks += 5;
            if (held_down !== m_held) begin
                failures++;
                $display("FAIL model_held t=%0t actual=%b expected=%b", $time, held_down, m_held);
            end
            if (just_pressed !== exp_jp) begin
                failures++;
                $display("FAIL model_jp t=%0t actual=%b expected=%b", $time, just_pressed, exp_jp);
            end
            if (just_released !== exp_jr) begin
                failures++;
                $display("FAIL model_jr t=%0t actual=%b expected=%b", $time, just_released, exp_jr);
            end
            if (repeat_pulse !== exp_rp) begin
                failures++;
                $display("FAIL model_rp t=%0t actual=%b expected=%b", $time, repeat_pulse, exp_rp);
            end
            if (tick !== exp_tick) begin
                failures++;
                $display("FAIL model_tick t=%0t actual=%b expected=%b", $time, tick, exp_tick);
            end
        end
    end

    // Hand-computed literal expectation.
    task automatic chk(input string name, input logic [NI-1:0] act, input logic [NI-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    // Negedge indices: E0 is the negedge after the first post-reset sample point.
    initial begin
        rst_n     = 1'b0;
        inputs    = 4'b0101;
        repeat_en = 4'b0000;
        @(negedge clk);
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);                                  // E0
        chk("rst_held", held_down, 4'b0101);
        chk("rst_tick", {3'b000, tick}, 4'b0001);
        chk("rst_jp", just_pressed, 4'b0000);

        // Bit 0 bounces every 3 cycles across two windows: no change accepted.
        for (int j = 0; j < 18; j++) begin
            if ((j % 3) == 0) inputs[0] = ~inputs[0];
            @(negedge clk);
        end                                              // E18
        chk("bounce_held", held_down, 4'b0101);

        // Press bit 1 (repeat enabled) and release bit 2; both accepted at E32.
        inputs    = 4'b0011;
        repeat_en = 4'b0010;
        repeat (14) @(negedge clk);                      // E32
        chk("press1_jp", just_pressed, 4'b0010);
        chk("press1_rp", repeat_pulse, 4'b0010);
        chk("rel2_jr", just_released, 4'b0100);
        chk("press1_held", held_down, 4'b0011);

        // Press bits 2 and 3 together; accepted at E48.
        repeat (4) @(negedge clk);                       // E36
        inputs    = 4'b1111;
        repeat_en = 4'b1110;
        repeat (12) @(negedge clk);                      // E48
        chk("press23_jp", just_pressed, 4'b1100);
        chk("press23_rp", repeat_pulse, 4'b1100);
        repeat (8) @(negedge clk);                       // E56
        chk("rep1_first", repeat_pulse, 4'b0010);

        // Release bit 2 so the release lands on its first-repeat sample point.
        repeat (7) @(negedge clk);                       // E63
        inputs = 4'b1011;
        repeat (9) @(negedge clk);                       // E72
        chk("rel2_jr_b", just_released, 4'b0100);
        chk("rel2_rp", repeat_pulse, 4'b1010);
        chk("rel2_held", held_down, 4'b1011);
        repeat (16) @(negedge clk);                      // E88
        chk("rep13_rate", repeat_pulse, 4'b1010);

        // One-cycle reset while bits 1 and 3 are repeating.
        repeat (2) @(negedge clk);                       // E90
        rst_n  = 1'b0;
        inputs = 4'b0000;
        @(negedge clk);
        chk("mrst_held", held_down, 4'b0000);
        chk("mrst_rp", repeat_pulse, 4'b0000);
        chk("mrst_tick", {3'b000, tick}, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);                                  // F0
        chk("mrst_tick1", {3'b000, tick}, 4'b0001);
        inputs    = 4'b1000;
        repeat_en = 4'b1000;
        repeat (16) @(negedge clk);                      // F16
        chk("repress3_jp", just_pressed, 4'b1000);
        chk("repress3_rp", repeat_pulse, 4'b1000);
        repeat (24) @(negedge clk);                      // F40
        chk("repress3_rep", repeat_pulse, 4'b1000);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_debounce_repeat.md
INPUT_DEBOUNCE_REPEAT -- requirements
Module: input_debounce_repeat

Interface
REQ-001 The block SHALL have parameter N_INPUTS, default 32, number of independent input channels.
REQ-002 The block SHALL have parameter TICK_BITS, default 17, giving a sample period of 2^TICK_BITS clocks.
REQ-003 The block SHALL have parameter REPEAT_DELAY, default 24, the number of ticks from an accepted press to the first auto-repeat; legal range 1..255.
REQ-004 The block SHALL have parameter REPEAT_RATE, default 4, the number of ticks between later auto-repeats; legal range 1..REPEAT_DELAY.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 inputs  input  N_INPUTS  raw, possibly bouncing levels; already synchronised to clk.
REQ-008 repeat_en  input  N_INPUTS  per-channel auto-repeat enable.
REQ-009 held_down  output  N_INPUTS  debounced level.
REQ-010 just_pressed  output  N_INPUTS  one-cycle pulse on an accepted 0->1 transition.
REQ-011 just_released  output  N_INPUTS  one-cycle pulse on an accepted 1->0 transition.
REQ-012 repeat_pulse  output  N_INPUTS  one-cycle pulse on an accepted press or an auto-repeat event.
REQ-013 tick  output  1  one-cycle pulse in the cycle after each sample point.

Function
REQ-014 A free-running TICK_BITS-bit counter SHALL increment every cycle and wrap; the cycle in which it equals 0 is the sample point.
REQ-015 Per channel, a pending bit SHALL be set to 1 at each sample point and cleared in any cycle where inputs[i] == held_down[i].
REQ-016 At a sample point, channel i SHALL toggle held_down[i] only if inputs[i] != held_down[i] in every cycle from the previous sample point up to and including the current one.
REQ-017 just_pressed, just_released and repeat_pulse SHALL be registered: they are high only in the cycle after the sample point, and 0 in all other cycles.
REQ-018 Each channel SHALL keep an 8-bit repeat counter, cleared to 0 at the sample point that accepts a press.
REQ-019 At each later sample point with held_down[i]=1, repeat_en[i]=1 and no release accepted: if counter == REPEAT_DELAY-1, the channel SHALL pulse repeat_pulse and load REPEAT_DELAY-REPEAT_RATE; otherwise it SHALL increment the counter.
REQ-020 The first auto-repeat therefore SHALL occur REPEAT_DELAY ticks after the press, and later ones every REPEAT_RATE ticks.
REQ-021 While repeat_en[i]=0, the channel's counter SHALL hold its value and emit no auto-repeat; re-enabling SHALL resume from the held value.
REQ-022 An accepted release SHALL clear the counter and suppress any repeat at that same sample point.
REQ-023 Channels SHALL be fully independent; simultaneous events on any subset of channels SHALL all be reported in the same cycle.
REQ-024 repeat_pulse SHALL be asserted at an accepted press regardless of repeat_en.

Reset
REQ-025 While rst_n=0, the tick counter, pending bits and repeat counters SHALL be 0.
REQ-026 While rst_n=0, held_down SHALL be loaded with inputs, and all pulse outputs and tick SHALL be 0.
REQ-027 Reset asserted mid-window or mid-repeat SHALL discard all in-progress state; no pulse SHALL be emitted for pre-reset activity.
REQ-028 The first sample point after reset SHALL accept no change, because all pending bits are 0.

Structure
REQ-029 The default parameter values and the repeat counter width (8) SHALL be defined as constants in shared package input_pkg.
REQ-030 Per-channel pending, level and repeat logic SHALL live in sub-module debounce_channel, instantiated N_INPUTS times by a generate loop; the top level owns only the tick counter.

Verification (N_INPUTS=4, TICK_BITS=3, REPEAT_DELAY=3, REPEAT_RATE=2)
REQ-031 Reset with inputs=4'b0101, release reset -> held_down=4'b0101 and no pulses through the first sample point.
REQ-032 Bit 0 toggling every 3 cycles across a full window -> held_down[0] unchanged and no pulses.
REQ-033 Bit 1 driven high for a full window -> just_pressed=4'b0010 and repeat_pulse=4'b0010 for 1 cycle after that sample point; held_down[1]=1.
REQ-034 Bit 1 held with repeat_en[1]=1 -> repeat_pulse[1] 3 ticks after the press, then every 2 ticks (press+3, +5, +7).
REQ-035 Bits 2 and 3 pressed in the same window, then bit 2 released just before its first repeat -> just_released[2] pulses with no repeat_pulse[2]; bit 3 keeps repeating.
REQ-036 rst_n pulsed low for 1 cycle while bit 3 is repeating -> all pulses are 0 and held_down takes the sampled inputs value; repeats restart only after a new accepted press.
